// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_addsub_pkg;

    localparam int unsigned ADDSUB_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle between a controller and serial_addsub.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_fulladder.sv
// One-bit full-adder cell; the only combinational datapath element.
module serial_addsub_fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic A,
    output logic cout
);
    assign A    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through a single
// full-adder cell, with start/busy/done handshake and registered result.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   s_sr;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               overflow_q;

    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;

    serial_addsub_fulladder u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry),
        .A    (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // S holds the low WIDTH-1 sum bits; the MSB joins them as the result is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            s_sr       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= (WIDTH-1)'({fa_sum, s_sr} >> 1);
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry here is the carry into the MSB
                        result_q   <= {fa_sum, s_sr};
                        cout_q     <= fa_cout;
                        overflow_q <= carry ^ fa_cout;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub against an arithmetic reference model.
module tb_serial_addsub;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands; returns {overflow, cout, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        longint ua, ub, sa, sb, ur, sr, m;
        logic c, o;
        logic [W-1:0] r;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - m : ua;
        sb = b[W-1] ? ub - m : ub;
        if (sub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            c  = (ur >= m);
            sr = sa + sb;
        end
        if (ur < 0) ur = ur + m;
        r = W'(ur % m);
        o = (sr > (m / 2) - 1) || (sr < -(m / 2));
        return {o, c, r};
    endfunction

    // Issue one operation; optionally pulse start with junk operands glitch_at cycles into RUN.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                         input int glitch_at, input string tag);
        logic [W+1:0] exp;
        int lat, bn;
        exp = model(ta, tb_, ts);
        lat = 0;
        bn  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.sub   = ts;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) bn++;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.sub   = 1'($urandom);
            end
            if (k == glitch_at)     bus.start = 1'b1;
            if (k == glitch_at + 1) bus.start = 1'b0;
        end
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_busy_cycles"}, bn, W);
        check({tag, "_result"}, bus.result, exp[W-1:0]);
        check({tag, "_cout"}, bus.cout, exp[W]);
        check({tag, "_overflow"}, bus.overflow, exp[W+1]);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_result_held"}, bus.result, exp[W-1:0]);
    endtask

    initial begin
        logic [W+1:0] exp;
        int d1, d2, n;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_cout", bus.cout, 0);
        check("reset_overflow", bus.overflow, 0);
        rst = 1'b0;

        do_op(16'h1234, 16'h4321, 1'b0, 0, "add");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, "wrap");
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        do_op(16'h8000, 16'h8000, 1'b0, 0, "ovf_neg");
        do_op(16'h0005, 16'h0007, 1'b1, 0, "sub_borrow");
        do_op(16'h0007, 16'h0005, 1'b1, 0, "sub_noborrow");
        do_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
        do_op(16'hABCD, 16'h1111, 1'b0, 5, "start_in_run");

        for (int i = 0; i < 20; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0, "random");

        // start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0F0F;
        bus.b     = 16'h1234;
        bus.sub   = 1'b1;
        exp = model(16'h0F0F, 16'h1234, 1'b1);
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 == 0) d1 = k;
                else begin
                    d2 = k;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_latency", d1, W + 1);
        check("b2b_spacing", d2 - d1, W + 2);
        check("b2b_result", bus.result, exp[W-1:0]);
        check("b2b_cout", bus.cout, exp[W]);
        repeat (W + 3) @(negedge clk);
        check("b2b_idle_busy", bus.busy, 0);

        // reset in the middle of a run discards the partial result
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1357;
        bus.b     = 16'h2468;
        bus.sub   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("pre_reset_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_cout", bus.cout, 0);
        n = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n++;
        end
        check("midrst_quiet", n, 0);
        do_op(16'h1357, 16'h2468, 1'b0, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
